lns_preproc_pipe: RTL and testbench
===================================

Name: lns_preproc_pipe

Overview:
- Parametrised, pipelined successor to the LNS fmadd preprocessor.
- Takes two signed log-domain operands x, y and an add/sub mode z_s.
- Produces the selected base operand w and the signed magnitude difference z, which feed the sb/db function lookup.
- Adds a valid/ready handshake, saturation, an equality flag and a tag passthrough; sits between operand fetch and the sb/db table stage.

Parameters:
- WIDTH, 11, bit width of signed log operands x, y, w, z.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  reset: asynchronous assert, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- x  input  WIDTH  signed log operand A.
- y  input  WIDTH  signed log operand B.
- z_s  input  1  mode: 1 = z gets |x-y| and w gets min; 0 = z gets -|x-y| and w gets max.
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- w  output  WIDTH  signed selected operand.
- z  output  WIDTH  signed saturated difference.
- sat  output  1  z was clipped to the representable range.
- eq  output  1  x == y; downstream uses this to flag the log(0) singularity on subtraction.
- out_tag  output  TAG_W  tag of this result.

Behaviour:
- Reset (n_rst low, asynchronous): both stage valids = 0, out_valid = 0, w = 0, z = 0, sat = 0, eq = 0, out_tag = 0. in_ready = 1 once reset is released.
- Reset mid-operation discards all in-flight beats; no output is produced for them.
- Pipeline: two register stages, fixed latency 2 cycles from input handshake to out_valid when there is no backpressure. Throughput 1 beat/cycle.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Flow control:
  - s2 advances when s2 is empty or out_ready = 1.
  - s1 advances when s1 is empty or s2 advances.
  - in_ready = !s1_valid || s2 advances. This is combinational from out_ready; no skid buffer is required.
  - Payload registers load only when their stage advances.
  - Under stall, all outputs hold stable until the output transfer.
- Stage 1 registers:
  - d = x - y, computed in WIDTH+1 bits. No wrap: sign-extend both operands before subtracting.
  - gt = (x > y), signed compare.
  - sel = z_s ? (gt ? y : x) : (gt ? x : y).
  - eq = (d == 0).
  - z_s and tag.
- Stage 2 registers:
  - m = |d|, held in WIDTH+1 bits. Maximum is 2^WIDTH - 1.
  - z_s = 1: z = min(m, 2^(WIDTH-1) - 1); sat = (m > 2^(WIDTH-1) - 1).
  - z_s = 0: z = -min(m, 2^(WIDTH-1)); sat = (m > 2^(WIDTH-1)).
  - w = sel; eq and tag pass through.
- Boundary conditions:
  - x == y gives z = 0, eq = 1, sat = 0, w = x.
  - Extreme operands never wrap; they always saturate.
  - Simultaneous input and output transfer on a full pipe advances both stages; no bubble and no loss.
  - out_valid deasserts only after an output transfer with no new beat behind it.

Decomposition:
- Package lns_pkg:
  - LNS_WIDTH default = 11.
  - typedef lns_t (logic signed [LNS_WIDTH-1:0]).
  - typedef struct lns_pre_s {w, z, sat, eq}.
  - localparams LNS_MAX and LNS_MIN.
- Sub-module lns_abs_sat (combinational, parametrised by WIDTH):
  - Inputs: d (WIDTH+1 bits) and neg (1 = -|d|).
  - Outputs: z and sat.
  - Instantiated in stage 2; reused later by the db/sb interpolation block.

Test Plan:
- Reset then single beat x=100, y=40, z_s=1, tag=3 -> 2 cycles later out_valid=1, w=40, z=60, sat=0, eq=0, out_tag=3.
- x=-5, y=20, z_s=0 -> w=20, z=-25, sat=0. Same operands with z_s=1 -> w=-5, z=25.
- Saturation:
  - x=1023, y=-1024, z_s=1 -> z=1023, sat=1, w=-1024.
  - Same operands with z_s=0 -> z=-1024, sat=1, w=1023.
  - x=512, y=-512, z_s=0 -> z=-1024, sat=0.
- Equality: x=y=-300, z_s=1 -> z=0, eq=1, sat=0, w=-300.
- Backpressure: stream 8 beats with tags 0..7 while out_ready toggles 1,0,0,1,... -> all 8 results emerge in order with no loss or duplication; in_ready deasserts while both stages are full and stalled; outputs stay stable during stall.
- Reset mid-stream: assert n_rst low with 2 beats in flight -> out_valid drops to 0 immediately (asynchronous) and all outputs read 0; after release, in_ready=1 and no stale beat appears.

Source files
------------

// File: rtl/lns_pkg.sv
// Shared types and limits for the LNS preprocessing and sb/db lookup datapath.
package lns_pkg;

    localparam int LNS_WIDTH = 11;

    typedef logic signed [LNS_WIDTH-1:0] lns_t;

    typedef struct packed {
        lns_t w;
        lns_t z;
        logic sat;
        logic eq;
    } lns_pre_s;

    localparam lns_t LNS_MAX = lns_t'(2**(LNS_WIDTH-1) - 1);
    localparam lns_t LNS_MIN = lns_t'(-(2**(LNS_WIDTH-1)));

endpackage

// File: rtl/lns_abs_sat.sv
// Combinational |d| or -|d| of a WIDTH+1 bit difference, clipped into WIDTH bits.
module lns_abs_sat #(
    parameter int WIDTH = 11
) (
    input  logic signed [WIDTH:0]   d,
    input  logic                    neg,
    output logic signed [WIDTH-1:0] z,
    output logic                    sat
);

    // The negative range reaches one step further than the positive one.
    localparam logic [WIDTH:0] POS_LIM = (WIDTH+1)'(2**(WIDTH-1) - 1);
    localparam logic [WIDTH:0] NEG_LIM = (WIDTH+1)'(2**(WIDTH-1));

    logic [WIDTH:0] mag;
    logic [WIDTH:0] lim;
    logic [WIDTH:0] clip;
    logic [WIDTH:0] neg_clip;

    always_comb begin
        mag      = d[WIDTH] ? $unsigned(-d) : $unsigned(d);
        lim      = neg ? NEG_LIM : POS_LIM;
        sat      = (mag > lim);
        clip     = sat ? lim : mag;
        neg_clip = -clip;
        z        = neg ? $signed(neg_clip[WIDTH-1:0]) : $signed(clip[WIDTH-1:0]);
    end

endmodule

// File: rtl/lns_preproc_pipe.sv
// Two-stage LNS fmadd preprocessor: picks the base operand w and the saturated
// signed magnitude difference z for the sb/db lookup, with valid/ready flow control.
module lns_preproc_pipe
    import lns_pkg::*;
#(
    parameter int WIDTH = LNS_WIDTH,
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic                    z_s,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] w,
    output logic signed [WIDTH-1:0] z,
    output logic                    sat,
    output logic                    eq,
    output logic [TAG_W-1:0]        out_tag
);

    logic                    s1_valid_reg;
    logic signed [WIDTH:0]   s1_d_reg;
    logic signed [WIDTH-1:0] s1_sel_reg;
    logic                    s1_eq_reg;
    logic                    s1_zs_reg;
    logic [TAG_W-1:0]        s1_tag_reg;

    logic                    s2_valid_reg;
    logic signed [WIDTH-1:0] w_reg;
    logic signed [WIDTH-1:0] z_reg;
    logic                    sat_reg;
    logic                    eq_reg;
    logic [TAG_W-1:0]        tag_reg;

    logic                    s1_adv;
    logic                    s2_adv;
    logic signed [WIDTH:0]   d_c;
    logic                    gt_c;
    logic signed [WIDTH-1:0] sel_c;
    logic signed [WIDTH-1:0] abs_z;
    logic                    abs_sat;

    // Ready ripples back combinationally from out_ready; no skid buffer.
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    // Sign-extend before subtracting so extreme operands cannot wrap.
    always_comb begin
        d_c   = {x[WIDTH-1], x} - {y[WIDTH-1], y};
        gt_c  = (x > y);
        sel_c = z_s ? (gt_c ? y : x) : (gt_c ? x : y);
    end

    lns_abs_sat #(.WIDTH(WIDTH)) u_abs_sat (
        .d   (s1_d_reg),
        .neg (!s1_zs_reg),
        .z   (abs_z),
        .sat (abs_sat)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid_reg <= 1'b0;
            s1_d_reg     <= '0;
            s1_sel_reg   <= '0;
            s1_eq_reg    <= 1'b0;
            s1_zs_reg    <= 1'b0;
            s1_tag_reg   <= '0;
            s2_valid_reg <= 1'b0;
            w_reg        <= '0;
            z_reg        <= '0;
            sat_reg      <= 1'b0;
            eq_reg       <= 1'b0;
            tag_reg      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= in_valid;
            end
            if (s1_adv && in_valid) begin
                s1_d_reg   <= d_c;
                s1_sel_reg <= sel_c;
                s1_eq_reg  <= (d_c == '0);
                s1_zs_reg  <= z_s;
                s1_tag_reg <= in_tag;
            end
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
            end
            // Payload holds after the last beat leaves, so outputs never glitch on bubbles.
            if (s2_adv && s1_valid_reg) begin
                w_reg   <= s1_sel_reg;
                z_reg   <= abs_z;
                sat_reg <= abs_sat;
                eq_reg  <= s1_eq_reg;
                tag_reg <= s1_tag_reg;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign w         = w_reg;
    assign z         = z_reg;
    assign sat       = sat_reg;
    assign eq        = eq_reg;
    assign out_tag   = tag_reg;

endmodule

// File: tb/tb_lns_preproc_pipe.sv
// Randomised and directed bench for lns_preproc_pipe against an arithmetic reference model.
module tb_lns_preproc_pipe;
    import lns_pkg::*;

    localparam int WIDTH = LNS_WIDTH;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    lns_t             x = '0;
    lns_t             y = '0;
    logic             z_s = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    lns_t             w;
    lns_t             z;
    logic             sat;
    logic             eq;
    logic [TAG_W-1:0] out_tag;

    lns_preproc_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .z_s       (z_s),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .w         (w),
        .z         (z),
        .sat       (sat),
        .eq        (eq),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int z;
        bit sat;
        bit eq;
        int tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_out = 0;

    bit   hold_pending = 1'b0;
    int   hold_w, hold_z, hold_tag;
    bit   hold_sat, hold_eq;
    bit   last_ov;
    int   last_w, last_z, last_tag;
    bit   last_sat, last_eq;
    bit   saw_stall;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: z is the signed distance folded to the mode's sign and clipped to the lns range.
    function automatic exp_t model(input int xv, input int yv, input bit zs, input int t);
        exp_t e;
        int   m;
        m = (xv > yv) ? xv - yv : yv - xv;
        if (zs) begin
            e.w   = (xv < yv) ? xv : yv;
            e.sat = (m > int'(LNS_MAX));
            e.z   = e.sat ? int'(LNS_MAX) : m;
        end else begin
            e.w   = (xv > yv) ? xv : yv;
            e.sat = (-m < int'(LNS_MIN));
            e.z   = e.sat ? int'(LNS_MIN) : -m;
        end
        e.eq  = (xv == yv);
        e.tag = t;
        return e;
    endfunction

    task automatic observe();
        exp_t e;
        last_ov  = out_valid;
        last_w   = int'(w);
        last_z   = int'(z);
        last_sat = sat;
        last_eq  = eq;
        last_tag = int'(out_tag);
        if (hold_pending) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_w", last_w, hold_w);
            check("stall_z", last_z, hold_z);
            check("stall_flags", {last_sat, last_eq}, {hold_sat, hold_eq});
            check("stall_tag", last_tag, hold_tag);
        end
        hold_pending = out_valid && !out_ready;
        hold_w = last_w; hold_z = last_z; hold_sat = last_sat;
        hold_eq = last_eq; hold_tag = last_tag;
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                $display("out tag=%0d w=%0d z=%0d sat=%0b eq=%0b", last_tag, last_w, last_z, last_sat, last_eq);
                check("w", last_w, e.w);
                check("z", last_z, e.z);
                check("sat", int'(last_sat), int'(e.sat));
                check("eq", int'(last_eq), int'(e.eq));
                check("tag", last_tag, e.tag);
            end
        end
    endtask

    task automatic cycle(input bit iv, input int xv, input int yv, input bit zs,
                         input int t, input bit ordy, output bit accepted);
        @(negedge clk);
        in_valid  = iv;
        x         = lns_t'(xv);
        y         = lns_t'(yv);
        z_s       = zs;
        in_tag    = TAG_W'(t);
        out_ready = ordy;
        #1;
        observe();
        accepted = iv && in_ready;
        if (accepted) sb.push_back(model(xv, yv, zs, t));
    endtask

    task automatic directed(input int xv, input int yv, input bit zs, input int t,
                            input int ew, input int ez, input bit esat, input bit eeq);
        bit acc;
        int lat;
        cycle(1'b1, xv, yv, zs, t, 1'b1, acc);
        check("dir_accept", int'(acc), 1);
        lat = 0;
        do begin
            lat++;
            cycle(1'b0, 0, 0, 1'b0, 0, 1'b1, acc);
        end while (!last_ov && lat < 8);
        check("dir_latency", lat, 2);
        check("dir_w", last_w, ew);
        check("dir_z", last_z, ez);
        check("dir_sat", int'(last_sat), int'(esat));
        check("dir_eq", int'(last_eq), int'(eeq));
        check("dir_tag", last_tag, t);
    endtask

    function automatic int rand_op();
        case ($urandom_range(0, 7))
            0:       return int'(LNS_MAX);
            1:       return int'(LNS_MIN);
            default: return int'($urandom_range(0, 2047)) - 1024;
        endcase
    endfunction

    initial begin
        bit acc;
        int tag_i, cyc, rx, ry;
        bit rzs, riv;

        // Reset state
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_w", int'(w), 0);
        check("rst_z", int'(z), 0);
        check("rst_flags_tag", {sat, eq, out_tag}, 0);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Directed values with hand-computed results
        directed(100, 40, 1'b1, 3, 40, 60, 1'b0, 1'b0);
        directed(-5, 20, 1'b0, 4, 20, -25, 1'b0, 1'b0);
        directed(-5, 20, 1'b1, 5, -5, 25, 1'b0, 1'b0);
        directed(1023, -1024, 1'b1, 6, -1024, 1023, 1'b1, 1'b0);
        directed(1023, -1024, 1'b0, 7, 1023, -1024, 1'b1, 1'b0);
        directed(512, -512, 1'b0, 8, 512, -1024, 1'b0, 1'b0);
        directed(-300, -300, 1'b1, 9, -300, 0, 1'b0, 1'b1);
        directed(-1024, 1023, 1'b0, 10, 1023, -1024, 1'b1, 1'b0);

        // Backpressure: 8 tagged beats, out_ready pattern 1,0,0 repeating
        n_out = 0;
        saw_stall = 1'b0;
        tag_i = 0;
        cyc = 0;
        while ((tag_i < 8 || sb.size() != 0) && cyc < 100) begin
            rx = rand_op();
            ry = rand_op();
            cycle(tag_i < 8, rx, ry, cyc[0], tag_i, (cyc % 3) == 0, acc);
            if (tag_i < 8 && !in_ready) saw_stall = 1'b1;
            if (acc) tag_i++;
            cyc++;
        end
        check("bp_all_out", n_out, 8);
        check("bp_in_ready_dropped", int'(saw_stall), 1);

        // Reset with two beats in flight
        cycle(1'b1, 7, 3, 1'b1, 1, 1'b0, acc);
        cycle(1'b1, 9, 2, 1'b0, 2, 1'b0, acc);
        cycle(1'b0, 0, 0, 1'b0, 0, 1'b0, acc);
        check("mid_full_before_rst", int'(out_valid), 1);
        #1 n_rst = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_w", int'(w), 0);
        check("mid_rst_z", int'(z), 0);
        check("mid_rst_flags_tag", {sat, eq, out_tag}, 0);
        sb.delete();
        hold_pending = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        check("mid_in_ready", int'(in_ready), 1);
        n_out = 0;
        repeat (5) cycle(1'b0, 0, 0, 1'b0, 0, 1'b1, acc);
        check("mid_no_stale", n_out, 0);

        // Randomised traffic with held beats until accepted
        riv = 1'b0;
        rx = 0; ry = 0; rzs = 1'b0; tag_i = 0;
        for (int i = 0; i < 600; i++) begin
            if (!riv) begin
                riv = ($urandom_range(0, 3) != 0);
                rx  = rand_op();
                ry  = ($urandom_range(0, 7) == 0) ? rx : rand_op();
                rzs = 1'($urandom_range(0, 1));
            end
            cycle(riv, rx, ry, rzs, tag_i, ($urandom_range(0, 2) != 0), acc);
            if (acc) begin
                riv = 1'b0;
                tag_i = (tag_i + 1) % 16;
            end
        end

        // Drain
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            cycle(1'b0, 0, 0, 1'b0, 0, 1'b1, acc);
            cyc++;
        end
        check("drain_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
